// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus definitions: owner codes, active-low enable levels and grant decode.
// Used by the arbiter, the master mux and the address decoder.
package yutorina_bus_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned BUS_OWNER_W = 2;

  typedef enum logic [BUS_OWNER_W-1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } bus_owner_e;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Active-low one-hot grant vector {m3..m0} for a given owner.
  function automatic logic [NUM_MASTERS-1:0] grant_decode(input bus_owner_e own);
    logic [NUM_MASTERS-1:0] g;
    g      = '1;
    g[own] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/yutorina_bus_rr_pick.sv
// Combinational round-robin picker: first requester after the current owner,
// searching owner+1, owner+2, owner+3 (mod 4). The owner itself is never picked.
module yutorina_bus_rr_pick
  import yutorina_bus_arbiter_pkg::*;
(
  input  bus_owner_e             i_owner,
  input  logic [NUM_MASTERS-1:0] i_req_n,
  output bus_owner_e             o_next,
  output logic                   o_valid
);

  bus_owner_e w_idx;

  // An X request compares as unknown, so the if falls through: not requesting.
  always_comb begin
    o_next  = i_owner;
    o_valid = 1'b0;
    w_idx   = i_owner;
    for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
      w_idx = bus_owner_e'(i_owner + k[BUS_OWNER_W-1:0]);
      if (!o_valid && (i_req_n[w_idx] == ENABLE_)) begin
        o_next  = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with bounded-hold preemption.
// Owner, grants and timeout_ are all registered; grants decode the next owner.
module yutorina_bus_arbiter
  import yutorina_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m_as_,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       timeout_
);

  localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  logic [NUM_MASTERS-1:0] w_req_n;
  bus_owner_e             r_owner;
  bus_owner_e             w_pick;
  bus_owner_e             w_owner_nxt;
  logic                   w_pick_valid;
  logic                   w_own_req;
  logic                   w_boundary;
  logic                   w_release;
  logic                   w_preempt;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic [NUM_MASTERS-1:0] r_grnt_n;
  logic                   r_timeout_n;

  assign w_req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

  yutorina_bus_rr_pick u_pick (
    .i_owner (r_owner),
    .i_req_n (w_req_n),
    .o_next  (w_pick),
    .o_valid (w_pick_valid)
  );

  // Release takes precedence: preemption only applies while the owner still requests.
  always_comb begin
    w_own_req = 1'b0;
    if (w_req_n[r_owner] == ENABLE_) w_own_req = 1'b1;
    w_boundary  = (m_as_ == DISABLE_) || (m_rdy_ == ENABLE_);
    w_release   = !w_own_req && w_pick_valid;
    w_preempt   = (MAX_HOLD != 0) && w_own_req && w_pick_valid &&
                  (r_hold_cnt == HOLD_MAX) && w_boundary;
    w_owner_nxt = (w_release || w_preempt) ? w_pick : r_owner;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_owner     <= BUS_OWNER_MASTER_0;
      r_grnt_n    <= grant_decode(BUS_OWNER_MASTER_0);
      r_timeout_n <= DISABLE_;
      r_hold_cnt  <= '0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_grnt_n    <= grant_decode(w_owner_nxt);
      r_timeout_n <= w_preempt ? ENABLE_ : DISABLE_;
      if ((w_owner_nxt != r_owner) || !w_own_req || !w_pick_valid)
        r_hold_cnt <= '0;
      else if (r_hold_cnt != HOLD_MAX)
        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

  assign m0_grnt_ = r_grnt_n[0];
  assign m1_grnt_ = r_grnt_n[1];
  assign m2_grnt_ = r_grnt_n[2];
  assign m3_grnt_ = r_grnt_n[3];
  assign owner    = r_owner;
  assign timeout_ = r_timeout_n;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench for yutorina_bus_arbiter: three instances (MAX_HOLD 16, 8, 0)
// share stimulus; expected owner/grant/timeout_ values are queued and checked after each edge.
module tb_yutorina_bus_arbiter;

  logic       clk    = 1'b0;
  logic       reset_ = 1'b1;
  logic [3:0] req_n  = 4'hF;
  logic       as_n   = 1'b1;
  logic       rdy_n  = 1'b1;

  logic [3:0] gnt_main, gnt_h8, gnt_h0;
  logic [1:0] own_main, own_h8, own_h0;
  logic       to_main, to_h8, to_h0;

  always #5 clk = ~clk;

  yutorina_bus_arbiter u_dut (
    .clk(clk), .reset_(reset_),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m_as_(as_n), .m_rdy_(rdy_n),
    .m0_grnt_(gnt_main[0]), .m1_grnt_(gnt_main[1]), .m2_grnt_(gnt_main[2]), .m3_grnt_(gnt_main[3]),
    .owner(own_main), .timeout_(to_main)
  );

  yutorina_bus_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .reset_(reset_),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m_as_(as_n), .m_rdy_(rdy_n),
    .m0_grnt_(gnt_h8[0]), .m1_grnt_(gnt_h8[1]), .m2_grnt_(gnt_h8[2]), .m3_grnt_(gnt_h8[3]),
    .owner(own_h8), .timeout_(to_h8)
  );

  yutorina_bus_arbiter #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .reset_(reset_),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m_as_(as_n), .m_rdy_(rdy_n),
    .m0_grnt_(gnt_h0[0]), .m1_grnt_(gnt_h0[1]), .m2_grnt_(gnt_h0[2]), .m3_grnt_(gnt_h0[3]),
    .owner(own_h0), .timeout_(to_h0)
  );

  typedef struct {
    string      tag;
    int         unit;
    logic [1:0] own;
    logic [3:0] gnt;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push_g(input string tag, input int unit, input logic [1:0] own,
                        input logic [3:0] gnt, input logic to);
    exp_t e;
    e.tag = tag; e.unit = unit; e.own = own; e.gnt = gnt; e.to = to;
    sb.push_back(e);
  endtask

  task automatic push(input string tag, input int unit, input logic [1:0] own, input logic to);
    push_g(tag, unit, own, ~(4'b0001 << own), to);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic drain();
    exp_t       e;
    logic [1:0] o;
    logic [3:0] g;
    logic       t;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.unit)
        0:       begin o = own_main; g = gnt_main; t = to_main; end
        1:       begin o = own_h8;   g = gnt_h8;   t = to_h8;   end
        default: begin o = own_h0;   g = gnt_h0;   t = to_h0;   end
      endcase
      n_total++;
      assert (o === e.own) n_pass++;
      else $error("FAIL %s owner unit=%0d observed=%0d expected=%0d", e.tag, e.unit, o, e.own);
      n_total++;
      assert (g === e.gnt) n_pass++;
      else $error("FAIL %s grants unit=%0d observed=%b expected=%b", e.tag, e.unit, g, e.gnt);
      n_total++;
      assert (t === e.to) n_pass++;
      else $error("FAIL %s timeout_ unit=%0d observed=%b expected=%b", e.tag, e.unit, t, e.to);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    req_n  = 4'hF;
    as_n   = 1'b1;
    rdy_n  = 1'b1;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "simulation timed out");
  end

  initial begin
    #1 reset_ = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) push("reset_init", u, 2'd0, 1'b1);
    drain();
    @(posedge clk);
    #1 reset_ = 1'b1;

    // m0 releases while m2 and m3 request
    req_n = 4'b0011;
    push_g("rel_0_to_2", 0, 2'd2, 4'b1011, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      push("m2_hold", 0, 2'd2, 1'b1);
      cycle();
    end
    check_int("hold_cnt_m2", int'(u_dut.r_hold_cnt), 3);

    // asynchronous reset while m2 owns, checked mid-cycle
    reset_ = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) push("reset_mid", u, 2'd0, 1'b1);
    drain();
    check_int("hold_cnt_reset", int'(u_dut.r_hold_cnt), 0);
    req_n = 4'hF;
    @(posedge clk);
    #1 reset_ = 1'b1;

    // wrap-around release order
    req_n = 4'b1011;
    push("to_m2", 0, 2'd2, 1'b1);
    cycle();
    req_n = 4'b0100;
    push("wrap_to_3", 0, 2'd3, 1'b1);
    cycle();
    check_int("hold_cnt_after_rel", int'(u_dut.r_hold_cnt), 0);
    req_n = 4'b1100;
    push("wrap_to_0", 0, 2'd0, 1'b1);
    cycle();
    req_n = 4'b1101;
    push("wrap_to_1", 0, 2'd1, 1'b1);
    cycle();

    // nobody requesting: owner parks
    req_n = 4'hF;
    for (int i = 0; i < 20; i++) begin
      push("park", 0, 2'd1, 1'b1);
      cycle();
    end

    // MAX_HOLD=8 preemption, deferral during an access, release priority
    do_reset();
    req_n = 4'b1101;
    push("h8_to_m1", 1, 2'd1, 1'b1);
    cycle();
    req_n = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      push("h8_hold", 1, 2'd1, 1'b1);
      cycle();
    end
    push("h8_preempt", 1, 2'd2, 1'b0);
    cycle();
    as_n  = 1'b0;
    rdy_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      push("h8_defer", 1, 2'd2, 1'b1);
      cycle();
    end
    check_int("h8_cnt_sat", int'(u_dut8.r_hold_cnt), 8);
    rdy_n = 1'b0;
    push("h8_boundary", 1, 2'd1, 1'b0);
    cycle();
    as_n  = 1'b1;
    rdy_n = 1'b1;
    push("h8_after", 1, 2'd1, 1'b1);
    cycle();
    as_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push("h8_inflight", 1, 2'd1, 1'b1);
      cycle();
    end
    req_n = 4'b1011;
    rdy_n = 1'b0;
    push("h8_rel_wins", 1, 2'd2, 1'b1);
    cycle();
    as_n  = 1'b1;
    rdy_n = 1'b1;
    push("h8_no_pulse", 1, 2'd2, 1'b1);
    cycle();

    // MAX_HOLD=0 never preempts; default MAX_HOLD=16 preempts after 16 counted cycles
    do_reset();
    req_n = 4'b1101;
    push("h0_to_m1", 2, 2'd1, 1'b1);
    cycle();
    req_n = 4'b1001;
    for (int k = 1; k <= 100; k++) begin
      push("h0_hold", 2, 2'd1, 1'b1);
      if (k <= 18)
        push("h16_hold", 0, (k < 17) ? 2'd1 : 2'd2, (k == 17) ? 1'b0 : 1'b1);
      cycle();
    end
    req_n = 4'b1011;
    push("h0_release", 2, 2'd2, 1'b1);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
